// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
// State encoding, default bus widths and AHB response codes.
package apb_bridge_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int NSLV_DEF = 3;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts APB ACCESS wait cycles; expired pulses on the cycle that would reach TIMEOUT_CYC.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Combinational so the FSM leaves ACCESS after exactly TIMEOUT_CYC waited cycles.
  assign expired = inc && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/apb_bridge_fsm_param.sv
// AHB-to-APB bridge controller: one APB transfer at a time, wait states, PSLVERR and decode errors.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_bridge_fsm_param
  import apb_bridge_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int NSLV        = NSLV_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            Hclk,
  input  logic            Hresetn,
  input  logic            valid,
  input  logic            Hwrite,
  input  logic [AW-1:0]   Haddr,
  input  logic [DW-1:0]   Hwdata,
  input  logic [NSLV-1:0] tempselx,
  output logic            Hreadyout,
  output logic            Hresp,
  output logic [DW-1:0]   Hrdata,
  output logic [AW-1:0]   Paddr,
  output logic [DW-1:0]   Pwdata,
  output logic            Pwrite,
  output logic [NSLV-1:0] Pselx,
  output logic            Penable,
  input  logic            Pready,
  input  logic            Pslverr,
  input  logic [DW-1:0]   Prdata
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t          state_q, state_d;
  logic [NSLV-1:0] sel_q;
  logic            ready_st;
  logic            sel_ok;
  logic            accept;
  logic            tmo_expired;

  function automatic logic is_onehot(input logic [NSLV-1:0] v);
    return (v != '0) && ((v & (v - NSLV'(1))) == '0);
  endfunction

  // ERR2 already drives Hreadyout=1, so it accepts the next address phase like IDLE.
  assign ready_st = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign sel_ok   = is_onehot(tempselx);
  assign accept   = ready_st && valid && sel_ok;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk     (Hclk),
    .rst_n   (Hresetn),
    .clr     (state_q == ST_SETUP),
    .inc     ((state_q == ST_ACCESS) && !Pready),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (!valid)       state_d = ST_IDLE;
        else if (!sel_ok) state_d = ST_ERR1;
        else if (Hwrite)  state_d = ST_WWAIT;
        else              state_d = ST_SETUP;
      end
      ST_WWAIT: state_d = ST_SETUP;
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready)           state_d = Pslverr ? ST_ERR1 : ST_IDLE;
        else if (tmo_expired) state_d = ST_ERR1;
        else                  state_d = ST_ACCESS;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Hreadyout = ready_st;
    Hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    Pselx     = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : '0;
    Penable   = (state_q == ST_ACCESS);
  end

  // Capture registers: APB address/direction/data hold between transfers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Paddr  <= '0;
      Pwrite <= 1'b0;
      sel_q  <= '0;
      Pwdata <= '0;
      Hrdata <= '0;
    end else begin
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        sel_q  <= tempselx;
      end
      if (state_q == ST_WWAIT) begin
        Pwdata <= Hwdata;
      end
      if ((state_q == ST_ACCESS) && Pready && !Pslverr && !Pwrite) begin
        Hrdata <= Prdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_bridge_fsm_param.sv
// Self-checking bench for apb_bridge_fsm_param: directed scenarios plus randomized transfers
// checked against a transaction-level timing model. Honours APB_TIMEOUT_EN with TIMEOUT_CYC=4.
module tb_apb_bridge_fsm_param;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NSLV = 3;
  localparam int TMO_CYC = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            Hclk = 1'b0;
  logic            Hresetn;
  logic            valid;
  logic            Hwrite;
  logic [AW-1:0]   Haddr;
  logic [DW-1:0]   Hwdata;
  logic [NSLV-1:0] tempselx;
  logic            Hreadyout;
  logic            Hresp;
  logic [DW-1:0]   Hrdata;
  logic [AW-1:0]   Paddr;
  logic [DW-1:0]   Pwdata;
  logic            Pwrite;
  logic [NSLV-1:0] Pselx;
  logic            Penable;
  logic            Pready;
  logic            Pslverr;
  logic [DW-1:0]   Prdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_paddr;
  logic          m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_hrdata;

  apb_bridge_fsm_param #(
    .AW (AW), .DW (DW), .NSLV (NSLV), .TIMEOUT_CYC (TMO_CYC)
  ) dut (
    .Hclk (Hclk), .Hresetn (Hresetn), .valid (valid), .Hwrite (Hwrite),
    .Haddr (Haddr), .Hwdata (Hwdata), .tempselx (tempselx),
    .Hreadyout (Hreadyout), .Hresp (Hresp), .Hrdata (Hrdata),
    .Paddr (Paddr), .Pwdata (Pwdata), .Pwrite (Pwrite), .Pselx (Pselx),
    .Penable (Penable), .Pready (Pready), .Pslverr (Pslverr), .Prdata (Prdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs for the edge that follows cycle k of a transfer; APB response only matters in ACCESS.
  task automatic drive_cycle(input int k, input int off, input int nacc, input int waits,
                             input logic wr, input logic [DW-1:0] wdata,
                             input logic [DW-1:0] rdata, input logic slverr);
    int j;
    j = k - (2 + off);
    valid    = 1'($urandom);
    Hwrite   = 1'($urandom);
    Haddr    = AW'($urandom);
    tempselx = NSLV'($urandom);
    Hwdata   = (wr && k <= 1) ? wdata : DW'($urandom);
    if (j >= 0 && j < nacc) begin
      Pready = (j >= waits);
      if (Pready) begin
        Prdata  = rdata;
        Pslverr = slverr;
      end else begin
        Prdata  = DW'($urandom);
        Pslverr = 1'($urandom);
      end
    end else begin
      Pready  = 1'($urandom);
      Pslverr = 1'($urandom);
      Prdata  = DW'($urandom);
    end
  endtask

  // Caller is at a negedge with the bridge ready; returns at the negedge where Hreadyout is back.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [NSLV-1:0] sel,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                          input int waits, input logic slverr);
    bit ok_sel, tmo, err, ok_read;
    int off, nacc, ka, kend;
    logic [DW-1:0] old_pwdata, old_hrdata;
    logic exp_rdy, exp_resp, in_setup, in_acc;
    ok_sel  = ($countones(sel) == 1);
    off     = (ok_sel && wr) ? 1 : 0;
    tmo     = ok_sel && TMO_ON && (waits >= TMO_CYC);
    nacc    = !ok_sel ? 0 : (tmo ? TMO_CYC : waits + 1);
    err     = !ok_sel || tmo || slverr;
    ok_read = ok_sel && !wr && !err;
    ka      = ok_sel ? 2 + off + nacc : 1;
    kend    = err ? ka + 1 : ka;
    old_pwdata = m_pwdata;
    old_hrdata = m_hrdata;
    if (ok_sel) begin
      m_paddr  = addr;
      m_pwrite = wr;
      if (wr) m_pwdata = wdata;
    end
    if (ok_read) m_hrdata = rdata;

    check_eq("pre_ready", 64'(Hreadyout), 64'(1));
    valid = 1'b1; Hwrite = wr; Haddr = addr; tempselx = sel;
    Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = DW'($urandom);
    @(posedge Hclk); #1;
    drive_cycle(0, off, nacc, waits, wr, wdata, rdata, slverr);
    for (int k = 1; k <= kend; k++) begin
      @(negedge Hclk);
      in_setup = ok_sel && (k == 1 + off);
      in_acc   = ok_sel && (k >= 2 + off) && (k < ka);
      if (k < ka) begin
        exp_rdy = 1'b0; exp_resp = 1'b0;
      end else if (err) begin
        exp_rdy = (k == ka + 1); exp_resp = 1'b1;
      end else begin
        exp_rdy = 1'b1; exp_resp = 1'b0;
      end
      check_eq("hreadyout", 64'(Hreadyout), 64'(exp_rdy));
      check_eq("hresp", 64'(Hresp), 64'(exp_resp));
      check_eq("pselx", 64'(Pselx), 64'((in_setup || in_acc) ? sel : '0));
      check_eq("penable", 64'(Penable), 64'(in_acc));
      check_eq("paddr", 64'(Paddr), 64'(m_paddr));
      check_eq("pwrite", 64'(Pwrite), 64'(m_pwrite));
      check_eq("pwdata", 64'(Pwdata), 64'((ok_sel && wr && k < 2) ? old_pwdata : m_pwdata));
      check_eq("hrdata", 64'(Hrdata), 64'((ok_read && k >= ka) ? m_hrdata : old_hrdata));
      if (k < kend) drive_cycle(k, off, nacc, waits, wr, wdata, rdata, slverr);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b0;
      Pready = 1'($urandom); Pslverr = 1'($urandom); Prdata = DW'($urandom);
      @(posedge Hclk);
      @(negedge Hclk);
      check_eq("idle_ready", 64'(Hreadyout), 64'(1));
      check_eq("idle_resp", 64'(Hresp), 64'(0));
      check_eq("idle_psel", 64'({Pselx, Penable}), 64'(0));
    end
  endtask

  initial begin
    Hresetn = 1'b0; valid = 1'b0; Hwrite = 1'b0; Haddr = '0; Hwdata = '0;
    tempselx = '0; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
    #1;
    check_eq("rst_ready", 64'(Hreadyout), 64'(1));
    check_eq("rst_resp", 64'(Hresp), 64'(0));
    check_eq("rst_psel_pen", 64'({Pselx, Penable, Pwrite}), 64'(0));
    check_eq("rst_paddr", 64'(Paddr), 64'(0));
    check_eq("rst_pwdata", 64'(Pwdata), 64'(0));
    check_eq("rst_hrdata", 64'(Hrdata), 64'(0));
    @(negedge Hclk); @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);

    run_xfer(1'b0, 32'h100, 3'b010, 32'h0, 32'hA5A5_0001, 0, 1'b0);
    run_xfer(1'b1, 32'h204, 3'b001, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
    run_xfer(1'b0, 32'h308, 3'b100, 32'h0, 32'h1234_5678, 1, 1'b1);
    run_xfer(1'b0, 32'h40C, 3'b000, 32'h0, 32'h0, 0, 1'b0);
    run_xfer(1'b1, 32'h510, 3'b011, 32'h5555_AAAA, 32'h0, 0, 1'b0);
    idle_cycles(1);
    run_xfer(1'b0, 32'h614, 3'b001, 32'h0, 32'hCAFE_F00D, 6, 1'b0);

    for (int t = 0; t < 200; t++) begin
      logic [NSLV-1:0] sel;
      if ($urandom_range(0, 4) == 0) sel = NSLV'($urandom);
      else sel = NSLV'(1) << $urandom_range(0, NSLV - 1);
      run_xfer(1'($urandom), AW'($urandom), sel, DW'($urandom), DW'($urandom),
               $urandom_range(0, 5), ($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    // Reset asserted in the middle of an ACCESS wait.
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h3C; tempselx = 3'b100; Pready = 1'b0;
    @(posedge Hclk); #1;
    valid = 1'b0;
    @(negedge Hclk);
    @(negedge Hclk);
    check_eq("mid_pen_before", 64'(Penable), 64'(1));
    #1 Hresetn = 1'b0;
    #1;
    check_eq("mid_rst_psel", 64'(Pselx), 64'(0));
    check_eq("mid_rst_pen", 64'(Penable), 64'(0));
    check_eq("mid_rst_ready", 64'(Hreadyout), 64'(1));
    check_eq("mid_rst_resp", 64'(Hresp), 64'(0));
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
    @(posedge Hclk);
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;
    check_eq("post_rst_ready", 64'(Hreadyout), 64'(1));
    check_eq("post_rst_psel", 64'({Pselx, Penable}), 64'(0));
    check_eq("post_rst_hrdata", 64'(Hrdata), 64'(0));
    check_eq("post_rst_paddr", 64'(Paddr), 64'(0));
    @(negedge Hclk);
    run_xfer(1'b0, 32'h700, 3'b010, 32'h0, 32'h0BAD_F00D, 2, 1'b0);

    valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
